i2s_rx_master: RTL and testbench
================================

Name: i2s_rx_master

Overview:
- I2S master receiver for a MEMS microphone (INMP441-class). Generates SCK and WS, deserialises SD, and emits one DATA_SIZE-bit sample per frame for the selected channel.
- Sample is presented with a single-cycle `ready` strobe.
- Sits directly upstream of the sample decimation stage; its `ready`/`audio_data` drive that stage's ready_i2s/audio_data_in.

Parameters:
- SCK_HALF_DIV, 4, clk cycles per SCK half-period. SCK period = 2*SCK_HALF_DIV clk. Must be >= 2.
- SLOT_BITS, 32, SCK cycles per channel slot. A frame is 2*SLOT_BITS SCK cycles.
- DATA_SIZE, 24, captured bits per sample, MSB first. Must be <= SLOT_BITS-1.
- CHANNEL, 0, captured slot: 0 = left (WS low), 1 = right (WS high).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, run the interface. Low stops and clears it.
- i2s_sd, input, 1, serial data from the microphone.
- i2s_sck, output, 1, bit clock to the microphone. Registered.
- i2s_ws, output, 1, word select. Registered.
- ready, output, 1, one-clk pulse: a new sample is on audio_data.
- audio_data, output, DATA_SIZE, last captured sample. Held until the next ready.

Behaviour:
- Reset: async on rst_n low. i2s_sck=0, i2s_ws=0, ready=0, audio_data=0; divider, frame counter and shift register cleared.
- Clock interface: this reset is asynchronous, active-low, rst_n; the clock is clk.
- Divider:
  - div_cnt counts 0..SCK_HALF_DIV-1. At terminal count it wraps to 0 and i2s_sck toggles.
  - sck_rise strobe: the 0->1 toggle cycle. sck_fall strobe: the 1->0 toggle cycle.
- Frame counter:
  - frame_cnt counts 0..2*SLOT_BITS-1 and advances on each sck_fall, wrapping to 0.
  - i2s_ws is updated on sck_fall: 1 when the new frame_cnt >= SLOT_BITS, else 0.
- Capture (Philips I2S, MSB one SCK after the WS edge):
  - slot_base = CHANNEL*SLOT_BITS; k = frame_cnt - slot_base.
  - On sck_rise with k in 1..DATA_SIZE: shift_reg <= {shift_reg[DATA_SIZE-2:0], i2s_sd}.
  - SD in every other bit position is ignored.
- Output:
  - On the sck_rise where k = DATA_SIZE, the next clk edge loads audio_data <= completed word and sets ready=1.
  - Latency: 1 clk after the LSB sampling edge.
  - ready is cleared on every other cycle. Exactly one pulse per frame; never two consecutive cycles high.
- Enable:
  - While enable=0: i2s_sck=0, i2s_ws=0, div_cnt=0, frame_cnt=0, shift_reg=0, ready=0. audio_data holds its last value.
  - enable 1->0 mid-slot: partial word discarded, no ready, SCK low on the next clk.
  - enable 0->1: starts at frame_cnt=0 with SCK low. The first rising edge of SCK occurs SCK_HALF_DIV clk later.
- Boundaries:
  - frame_cnt wrap 2*SLOT_BITS-1 -> 0 coincides with WS 1->0.
  - DATA_SIZE = SLOT_BITS-1 must still work: the LSB is captured at k = SLOT_BITS-1, before the WS toggle.
  - Async reset mid-frame aborts immediately; the first ready after release comes in the next full frame.
- Arithmetic:
  - Counter widths from $clog2: div_cnt $clog2(SCK_HALF_DIV), frame_cnt $clog2(2*SLOT_BITS).
  - No arithmetic on sample data; it is passed through raw two's-complement.
  - Elaboration-time assertions on parameter limits.

Decomposition:
- Package i2s_pkg:
  - DEFAULT_DATA_SIZE=24, DEFAULT_SLOT_BITS=32.
  - typedef enum logic {CH_LEFT=0, CH_RIGHT=1} i2s_channel_t.
  - Shared by this block, the decimation stage and the microphone bench model.
- Sub-module i2s_sck_gen (SCK_HALF_DIV; clk, rst_n, enable -> sck, sck_rise, sck_fall).
- Top: frame counter, WS, shift register and output register.

Test Plan:
- Reset/idle: rst_n=0, then enable=0 for 100 clk -> i2s_sck=0, i2s_ws=0, ready=0, audio_data=0 throughout.
- Clocking: SCK_HALF_DIV=4, enable=1 -> SCK period 8 clk, 4 clk high; WS toggles every 32 SCK falls; frame = 512 clk.
- Left capture: CHANNEL=0, mic model drives left=0xA5C3F1, right=0x123456 -> one ready per 512 clk, audio_data=0xA5C3F1, ready 1 clk after the SCK rise at frame_cnt=24.
- Right capture: CHANNEL=1, same stimulus -> audio_data=0x123456, ready 1 clk after the SCK rise at frame_cnt=56; never 0xA5C3F1.
- Abort: drop enable at frame_cnt=10 of the left slot, restore after 50 clk -> no ready during the abort, SCK low within 1 clk, first ready after restart carries a full correct word.
- Reset mid-frame: assert rst_n low for 3 clk at frame_cnt=40 with SD toggling -> all outputs 0 immediately; after release, the first ready is in the next full frame with the correct data.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by the receiver, the decimation stage and the microphone model.
package i2s_pkg;

   localparam int DEFAULT_DATA_SIZE = 24;
   localparam int DEFAULT_SLOT_BITS = 32;

   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } i2s_channel_t;

endpackage : i2s_pkg

// File: rtl/i2s_sck_gen.sv
// Bit-clock generator: divides clk into a registered SCK and flags the cycles in which it toggles.
module i2s_sck_gen
   import i2s_pkg::*;
#(
   parameter int SCK_HALF_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable_i,
   output logic sck_o,
   output logic sck_rise_o,
   output logic sck_fall_o
);

   localparam int DW = (SCK_HALF_DIV > 1) ? $clog2(SCK_HALF_DIV) : 1;
   localparam logic [DW-1:0] TERMINAL = DW'(SCK_HALF_DIV - 1);

   logic [DW-1:0] divCnt_q;
   logic [DW-1:0] divCnt_d;
   logic          sck_q;
   logic          sck_d;
   logic          atTerminal;

   assign atTerminal = enable_i && (divCnt_q == TERMINAL);

   always_comb begin
      divCnt_d = divCnt_q + DW'(1);
      sck_d    = sck_q;
      if (!enable_i) begin
         divCnt_d = '0;
         sck_d    = 1'b0;
      end else if (atTerminal) begin
         divCnt_d = '0;
         sck_d    = ~sck_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         divCnt_q <= '0;
         sck_q    <= 1'b0;
      end else begin
         divCnt_q <= divCnt_d;
         sck_q    <= sck_d;
      end
   end

   // Strobes are high in the cycle whose closing clk edge moves SCK.
   assign sck_o      = sck_q;
   assign sck_rise_o = atTerminal && !sck_q;
   assign sck_fall_o = atTerminal &&  sck_q;

endmodule : i2s_sck_gen

// File: rtl/i2s_rx_master.sv
// I2S master receiver: drives SCK/WS, deserialises SD (Philips framing) and emits one sample per frame.
module i2s_rx_master
   import i2s_pkg::*;
#(
   parameter int SCK_HALF_DIV = 4,
   parameter int SLOT_BITS    = DEFAULT_SLOT_BITS,
   parameter int DATA_SIZE    = DEFAULT_DATA_SIZE,
   parameter int CHANNEL      = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 i2s_sd,
   output logic                 i2s_sck,
   output logic                 i2s_ws,
   output logic                 ready,
   output logic [DATA_SIZE-1:0] audio_data
);

   localparam int FRAME_BITS = 2 * SLOT_BITS;
   localparam int FW         = $clog2(FRAME_BITS);
   localparam i2s_channel_t CH = (CHANNEL == 1) ? CH_RIGHT : CH_LEFT;
   localparam int SLOT_BASE  = (CH == CH_RIGHT) ? SLOT_BITS : 0;

   localparam logic [FW-1:0] FIRST_BIT  = FW'(SLOT_BASE + 1);
   localparam logic [FW-1:0] LAST_BIT   = FW'(SLOT_BASE + DATA_SIZE);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_BITS - 1);
   localparam logic [FW-1:0] WS_HIGH_AT = FW'(SLOT_BITS);

   if (SCK_HALF_DIV < 2) begin : gBadDiv
      $error("i2s_rx_master: SCK_HALF_DIV must be >= 2");
   end
   if (DATA_SIZE < 2 || DATA_SIZE > SLOT_BITS - 1) begin : gBadSize
      $error("i2s_rx_master: DATA_SIZE must lie in 2..SLOT_BITS-1");
   end
   if (CHANNEL != 0 && CHANNEL != 1) begin : gBadChannel
      $error("i2s_rx_master: CHANNEL must be 0 or 1");
   end

   logic                 sck;
   logic                 sckRise;
   logic                 sckFall;
   logic [FW-1:0]        frameCnt_q;
   logic [FW-1:0]        frameCnt_d;
   logic                 ws_q;
   logic [DATA_SIZE-1:0] shift_q;
   logic                 wordDone_q;
   logic                 wordDone_d;
   logic                 inSlot;
   logic                 ready_q;
   logic [DATA_SIZE-1:0] audio_q;

   i2s_sck_gen #(
      .SCK_HALF_DIV(SCK_HALF_DIV)
   ) u_sck_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable_i  (enable),
      .sck_o     (sck),
      .sck_rise_o(sckRise),
      .sck_fall_o(sckFall)
   );

   always_comb begin
      frameCnt_d = (frameCnt_q == FRAME_LAST) ? '0 : frameCnt_q + FW'(1);
      inSlot     = (frameCnt_q >= FIRST_BIT) && (frameCnt_q <= LAST_BIT);
      wordDone_d = sckRise && (frameCnt_q == LAST_BIT);
   end

   // The LSB lands in shift_q on the SCK rising edge; the word is published one clk later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frameCnt_q <= '0;
         ws_q       <= 1'b0;
         shift_q    <= '0;
         wordDone_q <= 1'b0;
         ready_q    <= 1'b0;
         audio_q    <= '0;
      end else if (!enable) begin
         frameCnt_q <= '0;
         ws_q       <= 1'b0;
         shift_q    <= '0;
         wordDone_q <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         wordDone_q <= wordDone_d;
         ready_q    <= wordDone_q;
         if (wordDone_q) begin
            audio_q <= shift_q;
         end
         if (sckFall) begin
            frameCnt_q <= frameCnt_d;
            ws_q       <= (frameCnt_d >= WS_HIGH_AT);
         end
         if (sckRise && inSlot) begin
            shift_q <= {shift_q[DATA_SIZE-2:0], i2s_sd};
         end
      end
   end

   assign i2s_sck    = sck;
   assign i2s_ws     = ws_q;
   assign ready      = ready_q;
   assign audio_data = audio_q;

endmodule : i2s_rx_master

// File: tb/tb_i2s_rx_master.sv
// Directed bench: left, right and 31-bit receivers share one microphone model driving fixed words.
module tb_i2s_rx_master;

   localparam logic [23:0] LEFT_WORD  = 24'hA5C3F1;
   localparam logic [23:0] RIGHT_WORD = 24'h123456;
   localparam logic [30:0] WIDE_WORD  = {LEFT_WORD, 7'h7F};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        micSd;

   logic        sckL, wsL, readyL;
   logic [23:0] audioL;
   logic        sckR, wsR, readyR;
   logic [23:0] audioR;
   logic        sckW, wsW, readyW;
   logic [30:0] audioW;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int readyCntL = 0, readyCntR = 0, readyCntW = 0, dblCnt = 0;
   int baseL, baseR, baseW, baseDbl;
   logic prevL = 1'b0, prevR = 1'b0, prevW = 1'b0;

   int          micIdx;
   logic        micPrevWs;
   logic [23:0] micWord;

   always #5 clk = ~clk;

   i2s_rx_master #(.SCK_HALF_DIV(4), .SLOT_BITS(32), .DATA_SIZE(24), .CHANNEL(0)) dutL (
      .clk(clk), .rst_n(rst_n), .enable(enable), .i2s_sd(micSd),
      .i2s_sck(sckL), .i2s_ws(wsL), .ready(readyL), .audio_data(audioL));

   i2s_rx_master #(.SCK_HALF_DIV(4), .SLOT_BITS(32), .DATA_SIZE(24), .CHANNEL(1)) dutR (
      .clk(clk), .rst_n(rst_n), .enable(enable), .i2s_sd(micSd),
      .i2s_sck(sckR), .i2s_ws(wsR), .ready(readyR), .audio_data(audioR));

   i2s_rx_master #(.SCK_HALF_DIV(4), .SLOT_BITS(32), .DATA_SIZE(31), .CHANNEL(0)) dutW (
      .clk(clk), .rst_n(rst_n), .enable(enable), .i2s_sd(micSd),
      .i2s_sck(sckW), .i2s_ws(wsW), .ready(readyW), .audio_data(audioW));

   // Microphone: MSB on the SCK fall after the WS edge, 24 data bits, then ones (also at the WS-edge bit).
   initial begin
      micSd     = 1'b1;
      micIdx    = 0;
      micPrevWs = 1'b0;
      micWord   = LEFT_WORD;
      forever begin
         @(negedge sckL or negedge rst_n or negedge enable);
         #1;
         if (!rst_n || !enable) begin
            micIdx    = 0;
            micPrevWs = 1'b0;
            micSd     = 1'b1;
         end else begin
            if (wsL != micPrevWs) micIdx = 0;
            else                  micIdx = micIdx + 1;
            micPrevWs = wsL;
            micWord   = wsL ? RIGHT_WORD : LEFT_WORD;
            if (micIdx >= 1 && micIdx <= 24) micSd = micWord[24 - micIdx];
            else                             micSd = 1'b1;
         end
      end
   end

   // Pulse counters observed away from the active edge.
   always @(negedge clk) begin
      if (readyL) readyCntL = readyCntL + 1;
      if (readyR) readyCntR = readyCntR + 1;
      if (readyW) readyCntW = readyCntW + 1;
      if ((readyL && prevL) || (readyR && prevR) || (readyW && prevW)) dblCnt = dblCnt + 1;
      prevL = readyL;
      prevR = readyR;
      prevW = readyW;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic rstnVal, input logic enVal);
      rst_n  = rstnVal;
      enable = enVal;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc = cyc + 1;
   endtask

   task automatic runTo(input int target);
      while (cyc < target) tick();
   endtask

   task automatic snapshot();
      baseL   = readyCntL;
      baseR   = readyCntR;
      baseW   = readyCntW;
      baseDbl = dblCnt;
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0);
      repeat (3) tick();
      checkOutput("reset_outputs", 32'({sckL, wsL, readyL, audioL}), 32'd0);

      @(negedge clk);
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 100; i++) begin
         tick();
         checkOutput("idle_left",  32'({sckL, wsL, readyL, audioL}), 32'd0);
         checkOutput("idle_right", 32'({sckR, wsR, readyR, audioR}), 32'd0);
         checkOutput("idle_wide",  32'({sckW, wsW, readyW, audioW}), 32'd0);
      end

      // Free-running from enable: SCK rises on clk 4, frame is 512 clk.
      applyStimulus(1'b1, 1'b1);
      cyc = 0;
      snapshot();
      runTo(3);   checkOutput("sck_low_before_first_rise", 32'(sckL), 32'd0);
      runTo(4);   checkOutput("sck_first_rise", 32'(sckL), 32'd1);
      runTo(7);   checkOutput("sck_high_phase", 32'(sckL), 32'd1);
      runTo(8);   checkOutput("sck_first_fall", 32'(sckL), 32'd0);
      runTo(196); checkOutput("left_ready_not_early", 32'(readyL), 32'd0);
      runTo(197); checkOutput("left_ready", 32'(readyL), 32'd1);
                  checkOutput("left_data", 32'(audioL), 32'(LEFT_WORD));
      runTo(198); checkOutput("left_ready_single", 32'(readyL), 32'd0);
      runTo(253); checkOutput("wide_ready", 32'(readyW), 32'd1);
                  checkOutput("wide_data", 32'(audioW), 32'(WIDE_WORD));
                  checkOutput("wide_ws_before_toggle", 32'(wsW), 32'd0);
      runTo(255); checkOutput("ws_low_slot", 32'(wsL), 32'd0);
      runTo(256); checkOutput("ws_rise", 32'(wsL), 32'd1);
      runTo(452); checkOutput("right_ready_not_early", 32'(readyR), 32'd0);
      runTo(453); checkOutput("right_ready", 32'(readyR), 32'd1);
                  checkOutput("right_data", 32'(audioR), 32'(RIGHT_WORD));
      runTo(511); checkOutput("ws_high_slot", 32'(wsL), 32'd1);
      runTo(512); checkOutput("ws_fall_at_wrap", 32'(wsL), 32'd0);
      runTo(709); checkOutput("left_ready_frame2", 32'(readyL), 32'd1);
                  checkOutput("left_data_frame2", 32'(audioL), 32'(LEFT_WORD));
      runTo(1030);
      checkOutput("left_pulses_two_frames",  32'(readyCntL - baseL), 32'd2);
      checkOutput("right_pulses_two_frames", 32'(readyCntR - baseR), 32'd2);
      checkOutput("wide_pulses_two_frames",  32'(readyCntW - baseW), 32'd2);
      checkOutput("no_double_ready", 32'(dblCnt - baseDbl), 32'd0);

      // Abort at frame_cnt=10 of the left slot (third frame starts at clk 1024).
      runTo(1106);
      snapshot();
      applyStimulus(1'b1, 1'b0);
      tick();
      checkOutput("abort_sck_low", 32'(sckL), 32'd0);
      checkOutput("abort_ws_low",  32'(wsL),  32'd0);
      repeat (49) tick();
      checkOutput("abort_no_ready", 32'(readyCntL + readyCntR + readyCntW - baseL - baseR - baseW), 32'd0);
      checkOutput("abort_sck_idle", 32'(sckL), 32'd0);
      checkOutput("abort_data_held", 32'(audioL), 32'(LEFT_WORD));

      applyStimulus(1'b1, 1'b1);
      cyc = 0;
      snapshot();
      runTo(196); checkOutput("restart_ready_not_early", 32'(readyL), 32'd0);
      runTo(197); checkOutput("restart_left_ready", 32'(readyL), 32'd1);
                  checkOutput("restart_left_data", 32'(audioL), 32'(LEFT_WORD));
      runTo(453); checkOutput("restart_right_ready", 32'(readyR), 32'd1);
                  checkOutput("restart_right_data", 32'(audioR), 32'(RIGHT_WORD));

      // Async reset at frame_cnt=40 while SCK is high in the right slot.
      runTo(838);
      checkOutput("pre_reset_sck_high", 32'(sckL), 32'd1);
      checkOutput("pre_reset_ws_high",  32'(wsL),  32'd1);
      applyStimulus(1'b0, 1'b1);
      #1;
      checkOutput("reset_now_left",  32'({sckL, wsL, readyL, audioL}), 32'd0);
      checkOutput("reset_now_right", 32'({sckR, wsR, readyR, audioR}), 32'd0);
      checkOutput("reset_now_wide",  32'(audioW), 32'd0);
      repeat (3) tick();
      checkOutput("reset_hold", 32'({sckL, wsL, readyL, audioL}), 32'd0);

      applyStimulus(1'b1, 1'b1);
      cyc = 0;
      snapshot();
      runTo(196); checkOutput("post_reset_ready_not_early", 32'(readyL), 32'd0);
      runTo(197); checkOutput("post_reset_left_ready", 32'(readyL), 32'd1);
                  checkOutput("post_reset_left_data", 32'(audioL), 32'(LEFT_WORD));
      runTo(253); checkOutput("post_reset_wide_data", 32'(audioW), 32'(WIDE_WORD));
      runTo(453); checkOutput("post_reset_right_ready", 32'(readyR), 32'd1);
                  checkOutput("post_reset_right_data", 32'(audioR), 32'(RIGHT_WORD));
      runTo(460);
      checkOutput("post_reset_left_pulses",  32'(readyCntL - baseL), 32'd1);
      checkOutput("post_reset_right_pulses", 32'(readyCntR - baseR), 32'd1);
      checkOutput("post_reset_no_double", 32'(dblCnt - baseDbl), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_i2s_rx_master
